fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_timeout.sv | 40 ++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // HALT is only reachable when the ack timeout is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_VALID,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;

  // RISC-V canonical NOP (addi x0, x0, 0), shown to decode before the first fetch.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Default number of ack-less REQ/DRAIN cycles before the fetch is declared dead.
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/fetch_timeout.sv
// Ack-wait counter for the fetch stage: clears on request entry, counts
// cycles without ack, and flags expiry on the LIMIT-th such cycle.
module fetch_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Expiry fires on the last counted cycle so the FSM leaves on that edge.
  assign expired = en && (count_q == LAST);

  // Next count: clear wins, otherwise count ack-less cycles up to the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one word per PC value over a req/ack
// memory port and hands it to decode over valid/ready. At most one memory
// request is outstanding; a flush during a pending read drains it.
// Optional feature macro: FETCH_TIMEOUT_EN (ack timeout, sticky fault, HALT).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         tmo_expired;

  assign mem_addr  = addr_q;
  assign instr_out = instr_q;
  assign instr_pc  = ipc_q;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q;

  // Counter restarts on every state change, so it is zero on REQ/DRAIN entry.
  fetch_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clr    (state_d != state_q),
    .en     (((state_q == ST_REQ) || (state_q == ST_DRAIN)) && !mem_ack),
    .expired(tmo_expired)
  );

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (tmo_expired) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_expired        = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  // Next-state and handshake outputs; pc_en is purely state/flush/ready driven.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    pc_en       = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flush here moves the PC on this edge, so capturing would be stale.
        if (flush) begin
          pc_en = 1'b1;
        end else begin
          addr_d  = pc_in;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        mem_req = 1'b1;
        if (flush) begin
          pc_en   = 1'b1;
          state_d = mem_ack ? ST_IDLE : ST_DRAIN;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          ipc_d   = addr_q;
          state_d = ST_VALID;
        end
      end

      ST_VALID: begin
        // Flush and handoff both advance the PC, but only ever once.
        instr_valid = 1'b1;
        if (flush || instr_ready) begin
          pc_en   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // The memory cannot cancel a read, so wait for its ack and drop the data.
        mem_req = 1'b1;
        pc_en   = flush;
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_expired) begin
      state_d = ST_HALT;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural PC register
// upstream and a scripted instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_q;
  logic [31:0] redir = '0;
  logic        pc_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_fault;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        fl;
    logic        rdy;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] redir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_pcen;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] IA = 32'h00500093;
  localparam logic [31:0] IB = 32'h00A00113;
  localparam logic [31:0] IC = 32'h00300193;
  localparam logic [31:0] ID = 32'h00400213;
  localparam logic [31:0] IE = 32'h00700393;

  fetch_unit #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_in      (pc_q),
    .pc_en      (pc_en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // Upstream PC register: +4 on a consumed instruction, redirect target on flush.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (pc_en) begin
      pc_q <= flush ? redir : pc_q + 32'd4;
    end
  end

  function automatic vec_t mk(input logic fl, input logic rdy, input logic ack,
                              input logic [31:0] rdata, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] instr, input logic [31:0] ipc,
                              input logic pcen, input logic flt);
    vec_t v;
    v.fl = fl; v.rdy = rdy; v.ack = ack; v.rdata = rdata; v.redir = rd;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_instr = instr;
    v.e_ipc = ipc; v.e_pcen = pcen; v.e_flt = flt;
    return v;
  endfunction

  task automatic chk(input string vn, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s %s: got %h expected %h", vn, f, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare all outputs mid-cycle.
  task automatic apply(input vec_t v, input string vn);
    flush       = v.fl;
    instr_ready = v.rdy;
    mem_ack     = v.ack;
    mem_rdata   = v.rdata;
    redir       = v.redir;
    #1;
    n_vec++;
    chk(vn, "mem_req",     32'(mem_req),     32'(v.e_req));
    chk(vn, "mem_addr",    mem_addr,         v.e_addr);
    chk(vn, "instr_valid", 32'(instr_valid), 32'(v.e_vld));
    chk(vn, "instr_out",   instr_out,        v.e_instr);
    chk(vn, "instr_pc",    instr_pc,         v.e_ipc);
    chk(vn, "pc_en",       32'(pc_en),       32'(v.e_pcen));
    chk(vn, "fetch_fault", 32'(fetch_fault), 32'(v.e_flt));
    $display("%s fl=%0d rdy=%0d ack=%0d req=%0d addr=%h vld=%0d instr=%h ipc=%h pc_en=%0d fault=%0d",
             vn, v.fl, v.rdy, v.ack, mem_req, mem_addr, instr_valid, instr_out, instr_pc, pc_en, fetch_fault);
  endtask

  initial begin
    //              fl rdy ack rdata         redir   | req addr    vld instr      ipc     pcen flt
    // Reset and first fetch, ack in first REQ cycle.
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h0,   0, NOP_INSTR, 32'h0,  0, 0));
    vecs.push_back(mk(0, 0, 1, IA,           32'h0,    1, 32'h0,   0, NOP_INSTR, 32'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,    0, 32'h0,   1, IA,        32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h0,   0, IA,        32'h0,  0, 0));
    // Slow memory: ack on the fourth REQ cycle.
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 32'h4,   0, IA,        32'h0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 32'h4,   0, IA,        32'h0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 32'h4,   0, IA,        32'h0,  0, 0));
    vecs.push_back(mk(0, 0, 1, IB,           32'h0,    1, 32'h4,   0, IA,        32'h0,  0, 0));
    // Backpressure for 5 cycles, with a stray ack that must be ignored.
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h4,   1, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 32'h0,    0, 32'h4,   1, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h4,   1, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h4,   1, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h4,   1, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,    0, 32'h4,   1, IB,        32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h4,   0, IB,        32'h4,  0, 0));
    // Flush while pending: drain at old address, next request at 0x40.
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h40,   1, 32'h8,   0, IB,        32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 32'h8,   0, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hBADBAD00, 32'h0,    1, 32'h8,   0, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h8,   0, IB,        32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 1, IC,           32'h0,    1, 32'h40,  0, IB,        32'h4,  0, 0));
    // Flush together with handoff: one pc_en, refetch at 0x80.
    vecs.push_back(mk(1, 1, 0, 32'h0,        32'h80,   0, 32'h40,  1, IC,        32'h40, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h40,  0, IC,        32'h40, 0, 0));
    vecs.push_back(mk(0, 0, 1, ID,           32'h0,    1, 32'h80,  0, IC,        32'h40, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h80,  1, ID,        32'h80, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,    0, 32'h80,  1, ID,        32'h80, 1, 0));
    // Flush in IDLE: no capture that cycle.
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h100,  0, 32'h80,  0, ID,        32'h80, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h80,  0, ID,        32'h80, 0, 0));
    // Flush coinciding with ack in REQ: data dropped.
    vecs.push_back(mk(1, 0, 1, 32'h11111111, 32'h200,  1, 32'h100, 0, ID,        32'h80, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 32'h100, 0, ID,        32'h80, 0, 0));
    // Request at 0x200 left unanswered for the timeout sequence.
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 32'h200, 0, ID,        32'h80, 0, 0));

    // Reset values while reset is held.
    repeat (2) @(negedge clock);
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, NOP_INSTR, 32'h0, 0, 0), "reset");

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clock);
      apply(vecs[i], $sformatf("t%0d", i));
    end

`ifdef FETCH_TIMEOUT_EN
    // Cycles 2..16 without ack keep the request up; then HALT with fault.
    for (int k = 2; k <= 16; k++) begin
      @(negedge clock);
      apply(mk(0, 0, 0, 32'h0, 32'h0, 1, 32'h200, 0, ID, 32'h80, 0, 0), $sformatf("wait%0d", k));
    end
    @(negedge clock);
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h200, 0, ID, 32'h80, 0, 1), "halt");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      apply(mk(1, 1, 1, 32'h0, 32'h300, 0, 32'h200, 0, ID, 32'h80, 0, 1), $sformatf("halt_fl%0d", k));
    end
`else
    // Without the timeout the request waits indefinitely.
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      apply(mk(0, 0, 0, 32'h0, 32'h0, 1, 32'h200, 0, ID, 32'h80, 0, 0), $sformatf("stall%0d", k));
    end
`endif

    // Asynchronous reset mid-cycle returns outputs immediately.
    @(negedge clock);
    #2;
    reset = 1'b0;
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, NOP_INSTR, 32'h0, 0, 0), "midreset");

    // Recovery fetch from PC 0 after reset release.
    @(negedge clock);
    reset = 1'b1;
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, NOP_INSTR, 32'h0, 0, 0), "rec_idle");
    @(negedge clock);
    apply(mk(0, 0, 1, IE,    32'h0, 1, 32'h0, 0, NOP_INSTR, 32'h0, 0, 0), "rec_req");
    @(negedge clock);
    apply(mk(0, 1, 0, 32'h0, 32'h0, 0, 32'h0, 1, IE,        32'h0, 1, 0), "rec_valid");
    @(negedge clock);
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, IE,        32'h0, 0, 0), "rec_idle2");
    @(negedge clock);
    apply(mk(0, 0, 0, 32'h0, 32'h0, 1, 32'h4, 0, IE,        32'h0, 0, 0), "rec_req2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
